// File: rtl/mux4_rr_sel.sv
// Round-robin 4:1 source arbiter with a one-word output register and valid/ready handshake.
// The grant is combinational; the selected word, its source index and the transfer count are registered.
module mux4_rr_sel #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       gnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  output logic [7:0]       xfer_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [1:0]       ptr_r;
  logic [1:0]       win_idx_s;
  logic             win_found_s;
  logic             load_s;
  logic [WIDTH-1:0] win_data_s;
  logic [WIDTH-1:0] out_data_r;
  logic [1:0]       out_sel_r;
  logic [7:0]       xfer_cnt_r;

  // Returns {found, index}; offsets are scanned high to low so the lowest offset from p wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Winner search, load decision and grant; rst gates the grant so it stays low during reset.
  always_comb begin
    {win_found_s, win_idx_s} = rr_pick(req, ptr_r);
    load_s = win_found_s && ((state_r == EMPTY) || out_ready) && !rst;
    gnt    = 4'b0000;
    if (load_s) begin
      gnt[win_idx_s] = 1'b1;
    end else begin
      gnt = 4'b0000;
    end
  end

  // Data select for the winning source.
  always_comb begin
    win_data_s = d0;
    case (win_idx_s)
      2'd0:    win_data_s = d0;
      2'd1:    win_data_s = d1;
      2'd2:    win_data_s = d2;
      2'd3:    win_data_s = d3;
      default: win_data_s = d0;
    endcase
  end

  // Next-state logic: a consumed word with a fresh load keeps FULL, giving back-to-back transfers.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        if (load_s) state_nxt_s = FULL;
        else        state_nxt_s = EMPTY;
      end
      FULL: begin
        if (out_ready && !load_s) state_nxt_s = EMPTY;
        else                      state_nxt_s = FULL;
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // State, output word, priority pointer and transfer counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= EMPTY;
      out_data_r <= '0;
      out_sel_r  <= 2'd0;
      ptr_r      <= 2'd0;
      xfer_cnt_r <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      if (load_s) begin
        out_data_r <= win_data_s;
        out_sel_r  <= win_idx_s;
        ptr_r      <= win_idx_s + 2'd1;
      end
      if ((state_r == FULL) && out_ready) begin
        xfer_cnt_r <= xfer_cnt_r + 8'd1;
      end
    end
  end

  assign out_valid = (state_r == FULL);
  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;
  assign xfer_cnt  = xfer_cnt_r;

endmodule

// File: tb/tb_mux4_rr_sel.sv
// Bench for mux4_rr_sel: table-driven cycle vectors plus hand-written reset and wrap sequences,
// with a scoreboard of granted words checked when the output holds and consumes them.
module tb_mux4_rr_sel;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] d0, d1, d2, d3;
  logic [3:0]  gnt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
  logic [7:0]  xfer_cnt;

  mux4_rr_sel #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req(req),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .gnt(gnt), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .xfer_cnt(xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] gnt;
    logic       valid;
    logic [7:0] cnt;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  sel;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;

  function automatic logic [31:0] dval(input int c, input int i);
    return {16'hA5A5, 12'(c), 2'b00, 2'(i)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
  endtask

  // One cycle: drive at negedge, check the combinational grant and registered outputs,
  // then update the scoreboard for the coming rising edge.
  task automatic cycle(input logic [3:0] r, input logic rd, input logic [3:0] eg,
                       input logic ev, input logic [7:0] ec);
    exp_t e;
    int   idx;
    @(negedge clk);
    req = r; out_ready = rd;
    d0 = dval(cyc, 0); d1 = dval(cyc, 1); d2 = dval(cyc, 2); d3 = dval(cyc, 3);
    #1;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("xfer_cnt", 32'(xfer_cnt), 32'(ec));
    if (ev) begin
      if (sb.size() == 0) begin
        chk("scoreboard_nonempty", 32'(0), 32'(1));
      end else begin
        chk("out_data", out_data, sb[0].data);
        chk("out_sel", 32'(out_sel), 32'(sb[0].sel));
        if (rd) void'(sb.pop_front());
      end
    end
    idx = -1;
    case (eg)
      4'b0001: idx = 0;
      4'b0010: idx = 1;
      4'b0100: idx = 2;
      4'b1000: idx = 3;
      default: idx = -1;
    endcase
    if (idx >= 0) begin
      e.data = dval(cyc, idx);
      e.sel  = 2'(idx);
      sb.push_back(e);
    end
    cyc++;
  endtask

  vec_t tbl[24];

  initial begin
    // Fill: 8-cycle full-rate rotation, pointer wrap with req=0101, 3-cycle stall, idle ready.
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 8'd0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 8'd0};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 8'd1};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 8'd2};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'd3};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 8'd4};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 8'd5};
    tbl[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 8'd6};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 8'd7};
    tbl[9]  = '{4'b0101, 1'b1, 4'b0001, 1'b0, 8'd8};
    tbl[10] = '{4'b0101, 1'b1, 4'b0100, 1'b1, 8'd8};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 8'd9};
    tbl[12] = '{4'b0100, 1'b0, 4'b0100, 1'b0, 8'd10};
    tbl[13] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 8'd10};
    tbl[14] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 8'd10};
    tbl[15] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 8'd10};
    tbl[16] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 8'd10};
    tbl[17] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'd11};
    for (int i = 18; i < 23; i++) tbl[i] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'd11};
    tbl[23] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'd11};

    rst = 1'b1; req = 4'b1111; out_ready = 1'b1;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_gnt", 32'(gnt), 32'(4'b0000));
    chk("rst_out_valid", 32'(out_valid), 32'(1'b0));
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_sel", 32'(out_sel), 32'(2'd0));
    chk("rst_xfer_cnt", 32'(xfer_cnt), 32'(8'd0));
    req = 4'b0000;
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 24; i++) cycle(tbl[i].req, tbl[i].rdy, tbl[i].gnt, tbl[i].valid, tbl[i].cnt);

    // Asynchronous reset while FULL and stalled.
    cycle(4'b1111, 1'b0, 4'b1000, 1'b0, 8'd11);
    cycle(4'b1111, 1'b0, 4'b0000, 1'b1, 8'd11);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'(1'b0));
    chk("async_rst_gnt", 32'(gnt), 32'(4'b0000));
    chk("async_rst_xfer_cnt", 32'(xfer_cnt), 32'(8'd0));
    chk("async_rst_out_data", out_data, 32'h0);
    sb.delete();
    req = 4'b0000;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    cycle(4'b1111, 1'b1, 4'b0001, 1'b0, 8'd0);

    // 256 back-to-back transfers from source 0, then check the counter wrap.
    for (int k = 1; k <= 256; k++) cycle(4'b0001, 1'b1, 4'b0001, 1'b1, 8'(k - 1));
    cycle(4'b0000, 1'b1, 4'b0000, 1'b1, 8'd0);
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mux4_rr_sel.md
MUX4_RR_SEL -- requirements
Module: mux4_rr_sel

Purpose: upstream stage of the 4:1 gate-level datapath mux. It arbitrates four requesting sources round-robin, registers the chosen word, and presents it with a valid/ready handshake.

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req, input, 4, per-source request; req[i] means source i holds a word on d<i>.
REQ-005 SHALL have ports d0, d1, d2, d3, input, WIDTH each, source data words.
REQ-006 SHALL have port gnt, output, 4, one-hot grant; gnt[i]=1 means source i's word is taken at this clock edge.
REQ-007 SHALL have port out_valid, output, 1, out_data/out_sel hold a word not yet consumed.
REQ-008 SHALL have port out_ready, input, 1, downstream accepts the word this cycle.
REQ-009 SHALL have port out_data, output, WIDTH, the registered selected word.
REQ-010 SHALL have port out_sel, output, 2, index of the source that supplied out_data.
REQ-011 SHALL have port xfer_cnt, output, 8, count of completed output transfers.

Function
REQ-012 SHALL implement two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 SHALL define load = (state==EMPTY or out_ready==1) and req!=0.
REQ-014 SHALL choose the winner as the first i with req[i]=1, searching in order ptr, ptr+1, ptr+2, ptr+3 (mod 4), where ptr is a 2-bit priority pointer.
REQ-015 SHALL drive gnt combinationally: one-hot winner when load=1, else 4'b0000; never more than one bit set.
REQ-016 SHALL, on a clock edge with load=1, register out_data from the winner's d<i> and out_sel=i, and set ptr=(i+1) mod 4; latency from req to out_valid is 1 cycle.
REQ-017 SHALL leave ptr unchanged on edges with load=0.
REQ-018 SHALL use these transitions: EMPTY→FULL on load; FULL→FULL on out_ready with load (back-to-back, no bubble), or on !out_ready; FULL→EMPTY on out_ready with req==0.
REQ-019 SHALL hold out_data and out_sel stable while out_valid=1 and out_ready=0; gnt=0 in that case.
REQ-020 SHALL treat out_ready while EMPTY as don't-care: no state change, no count.
REQ-021 SHALL increment xfer_cnt by 1 on each edge with out_valid=1 and out_ready=1, wrapping 255→0.
REQ-022 SHALL ignore d<i> of non-granted sources; req may change any cycle without side effects.
REQ-023 SHALL sustain throughput of one word per cycle while out_ready=1 and req!=0.

Reset
REQ-024 SHALL, while rst=1, force state=EMPTY, out_valid=0, out_data=0, out_sel=0, ptr=0, xfer_cnt=0, and gnt=4'b0000 regardless of req.
REQ-025 SHALL, on rst asserted mid-transfer, discard the held word with no gnt and no count; the first grant after release starts the search at source 0.

Verification
REQ-026 SHALL verify this scenario: reset, then req=4'b1111 with out_ready=1 held for 8 cycles → gnt sequence 0001,0010,0100,1000,0001,...; out_sel 0,1,2,3,0,... one cycle later; out_valid continuously 1; xfer_cnt=7 after the 8th edge.
REQ-027 SHALL verify this scenario: req=4'b0100, d2=32'hA5A5_0002, out_ready=0 for 3 cycles → one gnt=0100 pulse; out_data=32'hA5A5_0002, out_sel=2 stable and gnt=0 while stalled; then out_ready=1 with req=0 → out_valid falls next cycle and xfer_cnt=1.
REQ-028 SHALL verify this scenario: after a grant to source 3, req=4'b0101 → source 0 is granted first, then source 2.
REQ-029 SHALL verify this scenario: 256 transfers → xfer_cnt wraps to 0.
REQ-030 SHALL verify this scenario: rst pulsed while FULL with req=4'b1111 → out_valid=0 and gnt=0 immediately (asynchronous); after release the first grant is 0001.
REQ-031 SHALL verify this scenario: out_ready=1 while EMPTY with req=0 for 5 cycles → out_valid stays 0 and xfer_cnt stays 0.
